pipe_add_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the datapath ALU. It splits a WIDTH-bit operation into STAGES equal slices and resolves one slice per cycle, carrying the inter-slice carry through registers. It produces sum, carry-out, signed overflow and zero flags, with valid/ready flow control on both sides. It replaces single-cycle ripple adders wherever the full-width carry chain limits the clock period.

---
 rtl/pipe_add_sub_pkg.sv | 16 +
 rtl/pipe_add_sub_if.sv | 31 +++
 rtl/pipe_add_sub_add_slice.sv | 21 ++
 rtl/pipe_add_sub.sv | 143 ++++++++++++++
 tb/tb_pipe_add_sub.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_add_sub_pkg.sv
// Shared constants for the pipelined adder/subtractor: default geometry,
// slice-width derivation and the saturation limits for the default width.
package pipe_add_sub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int DEF_SLICE  = DEF_WIDTH / DEF_STAGES;

  localparam logic [DEF_WIDTH-1:0] DEF_SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] DEF_SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_add_sub_if.sv
// Operand/result handshake bundle for pipe_add_sub. The master drives
// operands and out_ready; the slave (the adder) drives results and in_ready.
interface pipe_add_sub_if
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             co;
  logic             ov;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, y, co, ov, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, y, co, ov, zero
  );

endinterface

// File: rtl/pipe_add_sub_add_slice.sv
// Combinational SLICE-bit adder used once per pipeline stage. Also exports
// the carry into its MSB so the top slice can form signed overflow.
module add_slice
  import pipe_add_sub_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

  // Carry into the MSB recovered from the MSB sum bit; valid even for SLICE=1.
  assign c_msb = a[SLICE-1] ^ b[SLICE-1] ^ s[SLICE-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement adder/subtractor: one SLICE-wide chunk per stage,
// carry registered between stages. Optional clamp: define PIPE_ADD_SUB_SAT_EN.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic           clk,
  input logic           rst_n,
  pipe_add_sub_if.slave bus
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic             co_q;
  logic             ov_q;
  logic             zero_q;

  // A bubble at the output never blocks; otherwise the whole pipe waits.
  assign advance      = !out_valid_q || bus.out_ready;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.co        = co_q;
  assign bus.ov        = ov_q;
  assign bus.zero      = zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * SLICE;
    localparam int REM  = WIDTH - DONE;

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] s;
    logic             ci;
    logic             vin;
    logic             c;
    logic             c_msb;
    logic [DONE-1:0]  res_nxt;

    add_slice #(.SLICE(SLICE)) u_slice (
      .a     (sa),
      .b     (sb),
      .ci    (ci),
      .s     (s),
      .co    (c),
      .c_msb (c_msb)
    );

    if (k == 0) begin : g_src
      assign sa      = bus.a[SLICE-1:0];
      assign sb      = b_eff[SLICE-1:0];
      assign ci      = bus.sub;
      assign vin     = bus.in_valid;
      assign res_nxt = s;
    end else begin : g_src
      assign sa      = g_stage[k-1].g_reg.a_q[SLICE-1:0];
      assign sb      = g_stage[k-1].g_reg.b_q[SLICE-1:0];
      assign ci      = g_stage[k-1].g_reg.carry_q;
      assign vin     = g_stage[k-1].g_reg.valid_q;
      assign res_nxt = {s, g_stage[k-1].g_reg.res_q};
    end

    if (k < STAGES - 1) begin : g_reg
      // Each stage keeps only the finished low slices and the unconsumed upper operands.
      logic            valid_q;
      logic            carry_q;
      logic [DONE-1:0] res_q;
      logic [REM-1:0]  a_q;
      logic [REM-1:0]  b_q;
      logic [REM-1:0]  a_up;
      logic [REM-1:0]  b_up;

      if (k == 0) begin : g_up
        assign a_up = bus.a[WIDTH-1:SLICE];
        assign b_up = b_eff[WIDTH-1:SLICE];
      end else begin : g_up
        assign a_up = g_stage[k-1].g_reg.a_q[REM+SLICE-1:SLICE];
        assign b_up = g_stage[k-1].g_reg.b_q[REM+SLICE-1:SLICE];
      end

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's old value on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          carry_q <= 1'b0;
          res_q   <= '0;
          a_q     <= '0;
          b_q     <= '0;
        end else if (advance) begin
          valid_q <= vin;
          carry_q <= c;
          res_q   <= res_nxt;
          a_q     <= a_up;
          b_q     <= b_up;
        end
      end
    end else begin : g_out
      logic             ov_nxt;
      logic [WIDTH-1:0] y_nxt;

      assign ov_nxt = c ^ c_msb;

`ifdef PIPE_ADD_SUB_SAT_EN
      localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
      localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

      // On overflow both operands share a sign; A's MSB picks the clamp direction.
      assign y_nxt = ov_nxt ? (sa[SLICE-1] ? SAT_MIN : SAT_MAX) : res_nxt;
`else
      assign y_nxt = res_nxt;
`endif

      // NOTE: datapath registers are reset too, so Y/flags read 0 after reset
      // rather than whatever was in flight.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          y_q         <= '0;
          co_q        <= 1'b0;
          ov_q        <= 1'b0;
          zero_q      <= 1'b0;
        end else if (advance) begin
          out_valid_q <= vin;
          y_q         <= y_nxt;
          co_q        <= c;
          ov_q        <= ov_nxt;
          zero_q      <= (y_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: directed vector table on the 4-stage
// build, plus latency on 1/32 stages, a stalled stream and mid-flight reset.
module tb_pipe_add_sub;
  import pipe_add_sub_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y_wrap;
    logic [W-1:0] y_sat;
    logic         co;
    logic         ov;
  } vec_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         sub       = 1'b0;
  logic         out_ready = 1'b1;
  logic         all_dut   = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_add_sub_if #(.WIDTH(W)) bus4 ();
  pipe_add_sub_if #(.WIDTH(W)) bus1 ();
  pipe_add_sub_if #(.WIDTH(W)) bus32 ();

  assign bus4.in_valid   = in_valid;
  assign bus4.a          = a;
  assign bus4.b          = b;
  assign bus4.sub        = sub;
  assign bus4.out_ready  = out_ready;
  assign bus1.in_valid   = in_valid && all_dut;
  assign bus1.a          = a;
  assign bus1.b          = b;
  assign bus1.sub        = sub;
  assign bus1.out_ready  = out_ready;
  assign bus32.in_valid  = in_valid && all_dut;
  assign bus32.a         = a;
  assign bus32.b         = b;
  assign bus32.sub       = sub;
  assign bus32.out_ready = out_ready;

  pipe_add_sub #(.WIDTH(W), .STAGES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  pipe_add_sub #(.WIDTH(W), .STAGES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_add_sub #(.WIDTH(W), .STAGES(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: full-width add, overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] z);
    logic [W-1:0] zb;
    logic [W:0]   sum;
    logic         ovf;
    logic [W-1:0] res;
    zb  = s ? ~z : z;
    sum = {1'b0, x} + {1'b0, zb} + {{W{1'b0}}, s};
    ovf = (x[W-1] == zb[W-1]) && (sum[W-1] != x[W-1]);
    res = sum[W-1:0];
`ifdef PIPE_ADD_SUB_SAT_EN
    if (ovf) res = x[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ovf, sum[W], res};
  endfunction

  task automatic single_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] z,
                           output logic [W-1:0] ry, output logic rco, output logic rov,
                           output logic rz, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; sub = s; a = x; b = z;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!bus4.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    ry  = bus4.y;
    rco = bus4.co;
    rov = bus4.ov;
    rz  = bus4.zero;
  endtask

  vec_t         vecs[10];
  logic [W-1:0] ry, y_exp;
  logic         rco, rov, rz;
  int           lat;

  initial begin
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 32'h0000_0002, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_y", bus4.y, 0);
    check("rst_flags", {bus4.co, bus4.ov, bus4.zero}, 0);
    check("rst_in_ready", bus4.in_ready, 1);
    #20 rst_n = 1'b1;

    // Same operation through 1, 4 and 32 stages.
    begin
      int       l1, l4, l32;
      logic [W+2:0] r1, r4, r32;
      l1 = 0; l4 = 0; l32 = 0;
      r1 = '0; r4 = '0; r32 = '0;
      all_dut = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; sub = 1'b0; a = 32'hFFFF_FFFF; b = 32'h0000_0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        if (bus1.out_valid && l1 == 0) begin
          l1 = cyc; r1 = {bus1.co, bus1.ov, bus1.zero, bus1.y};
        end
        if (bus4.out_valid && l4 == 0) begin
          l4 = cyc; r4 = {bus4.co, bus4.ov, bus4.zero, bus4.y};
        end
        if (bus32.out_valid && l32 == 0) begin
          l32 = cyc; r32 = {bus32.co, bus32.ov, bus32.zero, bus32.y};
        end
        @(posedge clk); #1;
      end
      all_dut = 1'b0;
      check("latency_s1", l1, 1);
      check("latency_s4", l4, 4);
      check("latency_s32", l32, 32);
      check("result_s1", r1, {3'b101, 32'h0});
      check("result_s4", r4, {3'b101, 32'h0});
      check("result_s32", r32, {3'b101, 32'h0});
    end

    for (int i = 0; i < 10; i++) begin
`ifdef PIPE_ADD_SUB_SAT_EN
      y_exp = vecs[i].y_sat;
`else
      y_exp = vecs[i].y_wrap;
`endif
      single_op(vecs[i].sub, vecs[i].a, vecs[i].b, ry, rco, rov, rz, lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_y", i), ry, y_exp);
      check($sformatf("vec%0d_co", i), rco, vecs[i].co);
      check($sformatf("vec%0d_ov", i), rov, vecs[i].ov);
      check($sformatf("vec%0d_zero", i), rz, (y_exp == '0));
    end

    // Back-to-back stream with OUT_READY low for cycles 5-7.
    begin
      logic         op_s[8];
      logic [W-1:0] op_a[8], op_b[8];
      logic [W+1:0] exp_r[8];
      logic [W+3:0] held;
      int           sent, got;
      for (int i = 0; i < 8; i++) begin
        op_s[i]  = 1'($urandom_range(0, 1));
        op_a[i]  = $urandom;
        op_b[i]  = $urandom;
        exp_r[i] = model(op_s[i], op_a[i], op_b[i]);
      end
      sent = 0; got = 0; held = '0;
      for (int t = 0; t < 60 && got < 8; t++) begin
        @(posedge clk); #1;
        out_ready = !(t >= 5 && t <= 7);
        if (sent < 8) begin
          in_valid = 1'b1; sub = op_s[sent]; a = op_a[sent]; b = op_b[sent];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (t >= 5 && t <= 7) begin
          check($sformatf("stall_in_ready_t%0d", t), bus4.in_ready, 0);
          if (t == 5) held = {bus4.out_valid, bus4.co, bus4.ov, bus4.zero, bus4.y};
          else check($sformatf("stall_hold_t%0d", t),
                     {bus4.out_valid, bus4.co, bus4.ov, bus4.zero, bus4.y}, held);
        end
        if (in_valid && bus4.in_ready) sent++;
        if (bus4.out_valid && bus4.out_ready) begin
          check($sformatf("stream%0d_result", got), {bus4.ov, bus4.co, bus4.y}, exp_r[got]);
          got++;
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_held_valid", held[W+3], 1);
      check("stream_count", got, 8);
    end

    // Reset with one result at the output and three operations in flight.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; sub = 1'b0; a = W'(i + 1); b = 32'h0000_0001;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_valid", bus4.out_valid, 1);
    check("pre_reset_y", bus4.y, 32'h0000_0002);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus4.out_valid, 0);
    check("mid_rst_y", bus4.y, 0);
    check("mid_rst_flags", {bus4.co, bus4.ov, bus4.zero}, 0);
    check("mid_rst_in_ready", bus4.in_ready, 1);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (bus4.out_valid) stale++;
      end
      check("no_stale_results", stale, 0);
    end
    single_op(1'b0, 32'h0000_00FF, 32'h0000_0001, ry, rco, rov, rz, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_y", ry, 32'h0000_0100);
    check("post_rst_flags", {rco, rov, rz}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
